ddr_rd_addr_arb: RTL and testbench
==================================

Name: ddr_rd_addr_arb

Overview:
- Parametrised N-channel read-address arbiter feeding the DDR3 read path.
- Each requesting source (PSI, ECM, EIT, spare...) writes read addresses into its own internal FIFO.
- The block grants one channel at a time, either round-robin or fixed-priority, and emits one address pulse per grant.
- Issue is gated by the downstream read-data FIFO full flag, and consecutive issues are spaced by a programmable gap so the read command path is never overrun.

Parameters:
- NUM_CH, 4, number of request channels (2..8).
- ADDR_W, 36, address/command word width.
- FIFO_DEPTH, 16, entries per channel FIFO; power of 2, 4..256.
- GAP_CYCLES, 6, cycles spent in HOLD after each issue; 1..15.
- PRIO_MODE, 0, 0 = round-robin, 1 = fixed priority (lowest index wins).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- addr_din  in  NUM_CH*ADDR_W  per-channel address; channel k occupies bits [k*ADDR_W +: ADDR_W].
- addr_din_en  in  NUM_CH  per-channel write strobe.
- rd_fifo_wfull  in  1  downstream read-data FIFO full; blocks new grants.
- addr_fifo_full  out  NUM_CH  per-channel FIFO full, registered.
- addr_overflow  out  NUM_CH  sticky flag: a write was dropped on that channel.
- ddr_addr_dout  out  ADDR_W  granted address.
- ddr_addr_dout_en  out  1  one-cycle valid pulse for ddr_addr_dout.
- ddr_ch_id  out  max(1,clog2(NUM_CH))  index of the channel that was granted.

Behaviour:
- **Reset:** rst is synchronous, active-high; clock is clk. On reset:
  - all FIFOs flushed (empty), state = IDLE, gap counter = 0, round-robin pointer = NUM_CH-1 (so channel 0 is checked first).
  - ddr_addr_dout = 0, ddr_addr_dout_en = 0, ddr_ch_id = 0, addr_fifo_full = 0, addr_overflow = 0.
- **Channel FIFOs:** first-word-fall-through, head visible while non-empty.
  - A write occurs when addr_din_en[k]=1 and the FIFO is not full.
  - A write while full is dropped and sets addr_overflow[k]; the flag clears only on rst.
  - Full is evaluated on the pre-pop count, so a write in the same cycle as a pop on a full FIFO is dropped.
  - A simultaneous write and pop on a non-full, non-empty FIFO keeps the count unchanged.
  - Write pointers wrap modulo FIFO_DEPTH.
- **State machine:** two states, IDLE and HOLD.
  - IDLE: if rd_fifo_wfull=0 and any FIFO is non-empty, then in that cycle T:
    - select winner w, pop head of FIFO w;
    - register its head into ddr_addr_dout, w into ddr_ch_id, and set ddr_addr_dout_en=1 at T+1;
    - go to HOLD with counter = 0.
  - IDLE otherwise: stay in IDLE; outputs 0.
  - HOLD: counter increments each cycle; return to IDLE when counter == GAP_CYCLES-1.
  - HOLD ignores requests and rd_fifo_wfull.
- **Latency and spacing:** one cycle from grant decision to pulse. Minimum spacing between en pulses is GAP_CYCLES+1 cycles (7 at default).
- **Output when idle:** when en=0, ddr_addr_dout=0 and ddr_ch_id=0. en is never high for two consecutive cycles.
- **Round-robin (PRIO_MODE=0):**
  - Search starts at (ptr+1) mod NUM_CH, wrapping; the first non-empty channel wins.
  - ptr <= w on each grant.
  - Any persistently requesting channel is served within NUM_CH grants.
- **Fixed priority (PRIO_MODE=1):** lowest-index non-empty channel wins; ptr is unused.
- **Write-to-visibility:** a word written at cycle T is visible to arbitration at T+1. An IDLE-state issue therefore occurs no earlier than T+1, with the pulse at T+2.
- **rd_fifo_wfull timing:** sampled only in IDLE. Asserting it during HOLD has no effect on an issue already made.
- **Reset mid-operation:** reset during HOLD, or in the cycle a pulse is due, suppresses the pulse. Next cycle outputs are 0 and the FIFOs are empty.

Test Plan:
- **Single channel latency:** reset; write 0x0_0000_1234 on ch2 at cycle 10 -> ddr_addr_dout_en=1 at cycle 12 with dout=0x0_0000_1234 and ch_id=2; all other cycles en=0 and dout=0.
- **Round-robin order:** PRIO_MODE=0; preload ch0={A0,A1}, ch1={B0}, ch3={D0,D1} -> issue order A0,B0,D0,A1,D1; pulses exactly 7 cycles apart.
- **Fixed priority:** PRIO_MODE=1, same preload -> order A0,A1,B0,D0,D1.
- **Backpressure:** hold rd_fifo_wfull=1 with ch1 non-empty for 20 cycles -> no pulse; deassert at cycle N -> pulse at N+1.
  - Also assert rd_fifo_wfull during HOLD -> the in-flight issue is unaffected, and the next issue is blocked.
- **Full/overflow:** write 17 words to ch0 with no grants possible (wfull=1) -> addr_fifo_full[0]=1 after the 16th write and addr_overflow[0]=1 after the 17th; then release wfull -> exactly 16 words drain, in order.
- **Reset mid-operation:** assert rst in the cycle after a grant decision -> no en pulse, all FIFOs empty, overflow flags cleared; next request is served from channel 0 first.

Source files
------------

// File: rtl/ddr_rd_addr_arb_if.sv
// Bundle of request, status and issue signals between the read-address
// sources and the DDR read-address arbiter.
interface ddr_rd_addr_arb_if #(
  parameter int NUM_CH = 4,
  parameter int ADDR_W = 36
) ();
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH*ADDR_W-1:0] addr_din;
  logic [NUM_CH-1:0]        addr_din_en;
  logic                     rd_fifo_wfull;
  logic [NUM_CH-1:0]        addr_fifo_full;
  logic [NUM_CH-1:0]        addr_overflow;
  logic [ADDR_W-1:0]        ddr_addr_dout;
  logic                     ddr_addr_dout_en;
  logic [CH_W-1:0]          ddr_ch_id;

  // Request sources plus the downstream full flag.
  modport master (
    output addr_din, addr_din_en, rd_fifo_wfull,
    input  addr_fifo_full, addr_overflow, ddr_addr_dout, ddr_addr_dout_en, ddr_ch_id
  );

  // The arbiter itself.
  modport slave (
    input  addr_din, addr_din_en, rd_fifo_wfull,
    output addr_fifo_full, addr_overflow, ddr_addr_dout, ddr_addr_dout_en, ddr_ch_id
  );
endinterface

// File: rtl/ddr_rd_addr_arb.sv
// N-channel read-address arbiter: per-channel FWFT FIFOs, round-robin or
// fixed-priority grant, one address pulse per grant, then a fixed gap.
module ddr_rd_addr_arb #(
  parameter int NUM_CH     = 4,
  parameter int ADDR_W     = 36,
  parameter int FIFO_DEPTH = 16,
  parameter int GAP_CYCLES = 6,
  parameter int PRIO_MODE  = 0
) (
  input  logic              clk,
  input  logic              rst,
  ddr_rd_addr_arb_if.slave  bus
);

  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int GAP_W = 4;

  typedef enum logic {IDLE, HOLD} state_e;

  logic [NUM_CH-1:0] not_empty;
  logic [NUM_CH-1:0] pop;
  logic [NUM_CH-1:0] full_vec;
  logic [NUM_CH-1:0] ovf_vec;
  logic [ADDR_W-1:0] head [NUM_CH];

  // ---------------------------------------------------------------------
  // Per-channel first-word-fall-through FIFOs
  // ---------------------------------------------------------------------
  for (genvar k = 0; k < NUM_CH; k++) begin : g_fifo
    logic [ADDR_W-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              full_q, ovf_q;
    logic              push;

    // Full is judged on the pre-pop count, so write+pop on a full FIFO drops the write.
    assign push         = bus.addr_din_en[k] && (cnt_q != CNT_W'(FIFO_DEPTH));
    assign not_empty[k] = (cnt_q != '0);
    assign head[k]      = mem_q[rd_ptr_q];
    assign full_vec[k]  = full_q;
    assign ovf_vec[k]   = ovf_q;

    // Occupancy after this cycle's push/pop.
    always_comb begin
      // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
      cnt_d = cnt_q;
      if (push && !pop[k])      cnt_d = cnt_q + CNT_W'(1);
      else if (!push && pop[k]) cnt_d = cnt_q - CNT_W'(1);
    end

    // Storage array: written only, never cleared.
    always_ff @(posedge clk) begin
      // NOTE: the data array has no reset; validity is tracked by the pointers and count, so clearing the storage would only add reset fan-out.
      if (push) mem_q[wr_ptr_q] <= bus.addr_din[k*ADDR_W +: ADDR_W];
    end

    // Pointers, count, registered full flag and sticky overflow.
    always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values regardless of statement order.
      if (rst) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        cnt_q    <= '0;
        full_q   <= 1'b0;
        ovf_q    <= 1'b0;
      end else begin
        if (push)   wr_ptr_q <= wr_ptr_q + PTR_W'(1);
        if (pop[k]) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        cnt_q  <= cnt_d;
        full_q <= (cnt_d == CNT_W'(FIFO_DEPTH));
        if (bus.addr_din_en[k] && !push) ovf_q <= 1'b1;
      end
    end
  end

  assign bus.addr_fifo_full = full_vec;
  assign bus.addr_overflow  = ovf_vec;

  // ---------------------------------------------------------------------
  // Winner selection
  // ---------------------------------------------------------------------
  logic [CH_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [CH_W-1:0] win_idx;
  logic            win_found;
  int              rr_idx;

  // Scan from the highest candidate rank down so the best-ranked hit is written last.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    rr_idx    = 0;
    if (PRIO_MODE == 1) begin
      for (int i = NUM_CH - 1; i >= 0; i--) begin
        if (not_empty[CH_W'(i)]) begin
          win_found = 1'b1;
          win_idx   = CH_W'(i);
        end
      end
    end else begin
      for (int i = NUM_CH; i >= 1; i--) begin
        rr_idx = (int'(rr_ptr_q) + i) % NUM_CH;
        if (not_empty[CH_W'(rr_idx)]) begin
          win_found = 1'b1;
          win_idx   = CH_W'(rr_idx);
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // Issue state machine
  // ---------------------------------------------------------------------
  state_e            state_q, state_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic [ADDR_W-1:0] dout_q, dout_d;
  logic              en_q, en_d;
  logic [CH_W-1:0]   id_q, id_d;

  // Next state, pops and the registered issue word.
  always_comb begin
    state_d  = state_q;
    gap_d    = gap_q;
    rr_ptr_d = rr_ptr_q;
    dout_d   = '0;
    en_d     = 1'b0;
    id_d     = '0;
    pop      = '0;
    unique case (state_q)
      IDLE: begin
        if (!bus.rd_fifo_wfull && win_found) begin
          pop[win_idx] = 1'b1;
          dout_d       = head[win_idx];
          id_d         = win_idx;
          en_d         = 1'b1;
          rr_ptr_d     = win_idx;
          gap_d        = '0;
          state_d      = HOLD;
        end
      end
      HOLD: begin
        gap_d = gap_q + GAP_W'(1);
        if (gap_q == GAP_W'(GAP_CYCLES - 1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, gap counter, round-robin pointer and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      gap_q    <= '0;
      rr_ptr_q <= CH_W'(NUM_CH - 1);
      dout_q   <= '0;
      en_q     <= 1'b0;
      id_q     <= '0;
    end else begin
      state_q  <= state_d;
      gap_q    <= gap_d;
      rr_ptr_q <= rr_ptr_d;
      dout_q   <= dout_d;
      en_q     <= en_d;
      id_q     <= id_d;
    end
  end

  // A reset arriving in the pulse cycle still cancels that pulse.
  assign bus.ddr_addr_dout_en = en_q & ~rst;
  assign bus.ddr_addr_dout    = rst ? '0 : dout_q;
  assign bus.ddr_ch_id        = rst ? '0 : id_q;

endmodule

// File: tb/tb_ddr_rd_addr_arb.sv
// Scoreboard bench for ddr_rd_addr_arb: a round-robin and a fixed-priority
// instance share stimulus; each has its own expected-issue queue.
module tb_ddr_rd_addr_arb;

  localparam int NUM_CH = 4;
  localparam int ADDR_W = 36;
  localparam int GAP    = 6;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [1:0]        ch;
  } exp_t;

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic [NUM_CH*ADDR_W-1:0] din = '0;
  logic [NUM_CH-1:0]        din_en = '0;
  logic                     wfull = 1'b0;

  int   tests = 0;
  int   failed = 0;
  int   cyc = 0;
  bit   mon_on = 1'b0;
  exp_t q_rr[$];
  exp_t q_fp[$];
  int   rr_times[$];
  int   fp_times[$];
  int   rr_last = -100;
  int   fp_last = -100;
  exp_t e_rr, e_fp;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ddr_rd_addr_arb_if #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W)) bus_rr ();
  ddr_rd_addr_arb_if #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W)) bus_fp ();

  assign bus_rr.addr_din      = din;
  assign bus_rr.addr_din_en   = din_en;
  assign bus_rr.rd_fifo_wfull = wfull;
  assign bus_fp.addr_din      = din;
  assign bus_fp.addr_din_en   = din_en;
  assign bus_fp.rd_fifo_wfull = wfull;

  ddr_rd_addr_arb #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .FIFO_DEPTH(16), .GAP_CYCLES(GAP), .PRIO_MODE(0))
    dut_rr (.clk(clk), .rst(rst), .bus(bus_rr.slave));
  ddr_rd_addr_arb #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .FIFO_DEPTH(16), .GAP_CYCLES(GAP), .PRIO_MODE(1))
    dut_fp (.clk(clk), .rst(rst), .bus(bus_fp.slave));

  // Round-robin instance monitor: pops scoreboard on pulses, checks idle zeros and spacing.
  always @(negedge clk) begin
    if (mon_on) begin
      tests++;
      if (bus_rr.ddr_addr_dout_en === 1'b1) begin
        rr_times.push_back(cyc);
        if (q_rr.size() == 0) begin
          failed++;
          $display("FAIL rr_unexpected_pulse: got addr=%h ch=%0d at cycle %0d, required no pulse",
                   bus_rr.ddr_addr_dout, bus_rr.ddr_ch_id, cyc);
        end else begin
          e_rr = q_rr.pop_front();
          if ({bus_rr.ddr_addr_dout, bus_rr.ddr_ch_id} !== e_rr) begin
            failed++;
            $display("FAIL rr_issue: got addr=%h ch=%0d, required addr=%h ch=%0d",
                     bus_rr.ddr_addr_dout, bus_rr.ddr_ch_id, e_rr.addr, e_rr.ch);
          end
        end
        if (cyc - rr_last < GAP + 1) begin
          failed++;
          $display("FAIL rr_spacing: got %0d cycles, required >= %0d", cyc - rr_last, GAP + 1);
        end
        rr_last = cyc;
      end else if (bus_rr.ddr_addr_dout_en !== 1'b0 || bus_rr.ddr_addr_dout !== '0 || bus_rr.ddr_ch_id !== '0) begin
        failed++;
        $display("FAIL rr_idle_outputs: got en=%b addr=%h ch=%0d, required all 0",
                 bus_rr.ddr_addr_dout_en, bus_rr.ddr_addr_dout, bus_rr.ddr_ch_id);
      end
    end
  end

  // Fixed-priority instance monitor.
  always @(negedge clk) begin
    if (mon_on) begin
      tests++;
      if (bus_fp.ddr_addr_dout_en === 1'b1) begin
        fp_times.push_back(cyc);
        if (q_fp.size() == 0) begin
          failed++;
          $display("FAIL fp_unexpected_pulse: got addr=%h ch=%0d at cycle %0d, required no pulse",
                   bus_fp.ddr_addr_dout, bus_fp.ddr_ch_id, cyc);
        end else begin
          e_fp = q_fp.pop_front();
          if ({bus_fp.ddr_addr_dout, bus_fp.ddr_ch_id} !== e_fp) begin
            failed++;
            $display("FAIL fp_issue: got addr=%h ch=%0d, required addr=%h ch=%0d",
                     bus_fp.ddr_addr_dout, bus_fp.ddr_ch_id, e_fp.addr, e_fp.ch);
          end
        end
        if (cyc - fp_last < GAP + 1) begin
          failed++;
          $display("FAIL fp_spacing: got %0d cycles, required >= %0d", cyc - fp_last, GAP + 1);
        end
        fp_last = cyc;
      end else if (bus_fp.ddr_addr_dout_en !== 1'b0 || bus_fp.ddr_addr_dout !== '0 || bus_fp.ddr_ch_id !== '0) begin
        failed++;
        $display("FAIL fp_idle_outputs: got en=%b addr=%h ch=%0d, required all 0",
                 bus_fp.ddr_addr_dout_en, bus_fp.ddr_addr_dout, bus_fp.ddr_ch_id);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "global timeout");
  end

  task automatic do_reset();
    @(negedge clk); #1;
    rst = 1'b1; din_en = '0; wfull = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic set_wfull(input logic v);
    @(negedge clk); #1 wfull = v;
  endtask

  task automatic wr1(input int ch, input logic [ADDR_W-1:0] a);
    @(negedge clk); #1;
    din_en = '0;
    din_en[ch] = 1'b1;
    din[ch*ADDR_W +: ADDR_W] = a;
    @(negedge clk); #1 din_en = '0;
  endtask

  task automatic push_both(input exp_t er, input exp_t ef);
    q_rr.push_back(er);
    q_fp.push_back(ef);
  endtask

  task automatic wait_pulses(input int n, input int budget, input string name);
    int k = 0;
    while ((rr_times.size() < n || fp_times.size() < n) && k < budget) begin
      @(posedge clk);
      k++;
    end
    tests++;
    if (rr_times.size() < n || fp_times.size() < n) begin
      failed++;
      $display("FAIL %s_timeout: got rr=%0d fp=%0d pulses, required %0d each",
               name, rr_times.size(), fp_times.size(), n);
    end
  endtask

  task automatic test_reset();
    do_reset();
    mon_on = 1'b1;
    @(negedge clk);
    tests++;
    if ({bus_rr.ddr_addr_dout_en, bus_rr.ddr_addr_dout, bus_rr.ddr_ch_id,
         bus_rr.addr_fifo_full, bus_rr.addr_overflow} !== '0) begin
      failed++;
      $display("FAIL reset_rr: got en=%b addr=%h ch=%0d full=%b ovf=%b, required all 0",
               bus_rr.ddr_addr_dout_en, bus_rr.ddr_addr_dout, bus_rr.ddr_ch_id,
               bus_rr.addr_fifo_full, bus_rr.addr_overflow);
    end
    tests++;
    if ({bus_fp.ddr_addr_dout_en, bus_fp.ddr_addr_dout, bus_fp.ddr_ch_id,
         bus_fp.addr_fifo_full, bus_fp.addr_overflow} !== '0) begin
      failed++;
      $display("FAIL reset_fp: got en=%b addr=%h ch=%0d full=%b ovf=%b, required all 0",
               bus_fp.ddr_addr_dout_en, bus_fp.ddr_addr_dout, bus_fp.ddr_ch_id,
               bus_fp.addr_fifo_full, bus_fp.addr_overflow);
    end
  endtask

  task automatic test_single_latency();
    int wc;
    do_reset();
    rr_times.delete(); fp_times.delete();
    repeat (7) @(negedge clk);
    push_both('{36'h0_0000_1234, 2'd2}, '{36'h0_0000_1234, 2'd2});
    @(negedge clk); #1;
    wc = cyc;
    din_en = 4'b0100;
    din[2*ADDR_W +: ADDR_W] = 36'h0_0000_1234;
    @(negedge clk); #1 din_en = '0;
    wait_pulses(1, 20, "latency");
    tests++;
    if (rr_times.size() < 1 || rr_times[0] != wc + 2) begin
      failed++;
      $display("FAIL latency_rr: got pulse at %0d, required %0d", rr_times.size() ? rr_times[0] : -1, wc + 2);
    end
    tests++;
    if (fp_times.size() < 1 || fp_times[0] != wc + 2) begin
      failed++;
      $display("FAIL latency_fp: got pulse at %0d, required %0d", fp_times.size() ? fp_times[0] : -1, wc + 2);
    end
    repeat (10) @(negedge clk);
  endtask

  task automatic test_arb_order();
    do_reset();
    set_wfull(1'b1);
    wr1(0, 36'hA0); wr1(1, 36'hB0); wr1(3, 36'hD0); wr1(0, 36'hA1); wr1(3, 36'hD1);
    push_both('{36'hA0, 2'd0}, '{36'hA0, 2'd0});
    push_both('{36'hB0, 2'd1}, '{36'hA1, 2'd0});
    push_both('{36'hD0, 2'd3}, '{36'hB0, 2'd1});
    push_both('{36'hA1, 2'd0}, '{36'hD0, 2'd3});
    push_both('{36'hD1, 2'd3}, '{36'hD1, 2'd3});
    rr_times.delete(); fp_times.delete();
    set_wfull(1'b0);
    wait_pulses(5, 100, "order");
    for (int i = 1; i < 5; i++) begin
      if (i < rr_times.size()) begin
        tests++;
        if (rr_times[i] - rr_times[i-1] != GAP + 1) begin
          failed++;
          $display("FAIL order_gap_rr[%0d]: got %0d, required %0d", i, rr_times[i] - rr_times[i-1], GAP + 1);
        end
      end
      if (i < fp_times.size()) begin
        tests++;
        if (fp_times[i] - fp_times[i-1] != GAP + 1) begin
          failed++;
          $display("FAIL order_gap_fp[%0d]: got %0d, required %0d", i, fp_times[i] - fp_times[i-1], GAP + 1);
        end
      end
    end
    repeat (10) @(negedge clk);
  endtask

  task automatic test_backpressure();
    int n;
    do_reset();
    set_wfull(1'b1);
    wr1(1, 36'h1_2345_6789);
    repeat (20) @(negedge clk);
    rr_times.delete(); fp_times.delete();
    push_both('{36'h1_2345_6789, 2'd1}, '{36'h1_2345_6789, 2'd1});
    #1;
    n = cyc;
    wfull = 1'b0;
    wait_pulses(1, 20, "bp_release");
    tests++;
    if (rr_times.size() < 1 || fp_times.size() < 1 || rr_times[0] != n + 1 || fp_times[0] != n + 1) begin
      failed++;
      $display("FAIL bp_release_cycle: got rr=%0d fp=%0d, required %0d",
               rr_times.size() ? rr_times[0] : -1, fp_times.size() ? fp_times[0] : -1, n + 1);
    end
    repeat (10) @(negedge clk);
    // wfull raised during HOLD: in-flight issue stands, the next one waits.
    rr_times.delete(); fp_times.delete();
    push_both('{36'hC1, 2'd1}, '{36'hC1, 2'd1});
    wr1(1, 36'hC1);
    wr1(1, 36'hC2);
    wait_pulses(1, 20, "bp_inflight");
    set_wfull(1'b1);
    repeat (20) @(negedge clk);
    tests++;
    if (rr_times.size() != 1 || fp_times.size() != 1) begin
      failed++;
      $display("FAIL bp_blocked: got rr=%0d fp=%0d pulses, required 1 each", rr_times.size(), fp_times.size());
    end
    push_both('{36'hC2, 2'd1}, '{36'hC2, 2'd1});
    set_wfull(1'b0);
    wait_pulses(2, 20, "bp_resume");
    repeat (10) @(negedge clk);
  endtask

  task automatic test_full_overflow();
    do_reset();
    set_wfull(1'b1);
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      if (i == 15) begin
        tests++;
        if (bus_rr.addr_fifo_full[0] !== 1'b0 || bus_fp.addr_fifo_full[0] !== 1'b0) begin
          failed++;
          $display("FAIL full_after_15: got rr=%b fp=%b, required 0", bus_rr.addr_fifo_full[0], bus_fp.addr_fifo_full[0]);
        end
      end
      if (i == 16) begin
        tests++;
        if (bus_rr.addr_fifo_full !== 4'b0001 || bus_fp.addr_fifo_full !== 4'b0001 ||
            bus_rr.addr_overflow !== 4'b0000 || bus_fp.addr_overflow !== 4'b0000) begin
          failed++;
          $display("FAIL full_after_16: got full rr=%b fp=%b ovf rr=%b fp=%b, required full=0001 ovf=0000",
                   bus_rr.addr_fifo_full, bus_fp.addr_fifo_full, bus_rr.addr_overflow, bus_fp.addr_overflow);
        end
      end
      #1;
      din_en = 4'b0001;
      din[0 +: ADDR_W] = 36'h100 + ADDR_W'(i);
    end
    @(negedge clk);
    tests++;
    if (bus_rr.addr_overflow !== 4'b0001 || bus_fp.addr_overflow !== 4'b0001) begin
      failed++;
      $display("FAIL overflow_after_17: got rr=%b fp=%b, required 0001", bus_rr.addr_overflow, bus_fp.addr_overflow);
    end
    #1 din_en = '0;
    for (int i = 0; i < 16; i++)
      push_both('{36'h100 + ADDR_W'(i), 2'd0}, '{36'h100 + ADDR_W'(i), 2'd0});
    rr_times.delete(); fp_times.delete();
    set_wfull(1'b0);
    wait_pulses(16, 200, "drain");
    repeat (20) @(negedge clk);
    tests++;
    if (rr_times.size() != 16 || fp_times.size() != 16 || bus_rr.addr_fifo_full !== '0 || bus_rr.addr_overflow !== 4'b0001) begin
      failed++;
      $display("FAIL drain_count: got rr=%0d fp=%0d pulses full=%b ovf=%b, required 16 pulses full=0000 ovf=0001",
               rr_times.size(), fp_times.size(), bus_rr.addr_fifo_full, bus_rr.addr_overflow);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    set_wfull(1'b1);
    for (int i = 0; i < 17; i++) begin
      @(negedge clk); #1;
      din_en = 4'b1000;
      din[3*ADDR_W +: ADDR_W] = 36'h300 + ADDR_W'(i);
    end
    @(negedge clk); #1 din_en = '0;
    wr1(0, 36'hAAA);
    tests++;
    if (bus_rr.addr_overflow !== 4'b1000 || bus_fp.addr_overflow !== 4'b1000) begin
      failed++;
      $display("FAIL mid_pre_overflow: got rr=%b fp=%b, required 1000", bus_rr.addr_overflow, bus_fp.addr_overflow);
    end
    // Grant decided with wfull low; reset lands in the cycle the pulse is due.
    set_wfull(1'b0);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    tests++;
    if (bus_rr.addr_overflow !== '0 || bus_fp.addr_overflow !== '0 ||
        bus_rr.addr_fifo_full !== '0 || bus_fp.addr_fifo_full !== '0) begin
      failed++;
      $display("FAIL mid_flags_cleared: got ovf rr=%b fp=%b full rr=%b fp=%b, required all 0",
               bus_rr.addr_overflow, bus_fp.addr_overflow, bus_rr.addr_fifo_full, bus_fp.addr_fifo_full);
    end
    rr_times.delete(); fp_times.delete();
    repeat (20) @(negedge clk);
    tests++;
    if (rr_times.size() != 0 || fp_times.size() != 0) begin
      failed++;
      $display("FAIL mid_fifos_empty: got rr=%0d fp=%0d pulses, required 0", rr_times.size(), fp_times.size());
    end
    push_both('{36'hE0, 2'd0}, '{36'hE0, 2'd0});
    push_both('{36'hE1, 2'd1}, '{36'hE1, 2'd1});
    @(negedge clk); #1;
    din_en = 4'b0011;
    din[0 +: ADDR_W]      = 36'hE0;
    din[ADDR_W +: ADDR_W] = 36'hE1;
    @(negedge clk); #1 din_en = '0;
    wait_pulses(2, 40, "mid_after");
    repeat (10) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single_latency();
    test_arb_order();
    test_backpressure();
    test_full_overflow();
    test_reset_mid();
    tests++;
    if (q_rr.size() != 0 || q_fp.size() != 0) begin
      failed++;
      $display("FAIL scoreboard_leftover: got rr=%0d fp=%0d pending, required 0", q_rr.size(), q_fp.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
